int_issue_queue_mp: RTL and testbench
=====================================

# int_issue_queue_mp

Parametrised integer issue queue: the next generation of the integer issue unit. It buffers dispatched integer micro-ops in an age-ordered collapsing queue and tracks source-operand readiness. Readiness is woken by `NUM_WB` writeback tag broadcasts. Each cycle it issues the oldest ready entry to the integer execute stage under a valid/ready handshake, and it supports a full pipeline flush. It sits between dispatch and integer execute.

## Interface
Parameters:
- `DEPTH`, 8: number of queue entries; must be ≥ 2.
- `TAG_W`, 6: width of physical-register tags.
- `PAYLOAD_W`, 64: opaque micro-op payload (opcode, immediate, ROB id), passed through unchanged.
- `NUM_WB`, 2: number of wakeup broadcast ports.
- `CNT_W`, `$clog2(DEPTH+1)`: occupancy counter width (derived).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_aL`  in  1  reset; synchronous, active-low.
- `flush`  in  1  discard all entries.
- `dispatch_valid`  in  1  dispatch offers an entry.
- `dispatch_ready`  out  1  queue accepts an entry this cycle.
- `dispatch_src1_tag`, `dispatch_src2_tag`, `dispatch_dst_tag`  in  `TAG_W` each  operand tags.
- `dispatch_src1_rdy`, `dispatch_src2_rdy`  in  1 each  operand already available.
- `dispatch_payload`  in  `PAYLOAD_W`  micro-op payload.
- `wb_valid`  in  `NUM_WB`  wakeup broadcast valid, one bit per port.
- `wb_tag`  in  `NUM_WB*TAG_W`  wakeup tags, packed; port i occupies bits `[i*TAG_W +: TAG_W]`.
- `issue_valid`  out  1  an issuable entry is presented.
- `issue_ready`  in  1  execute accepts it.
- `issue_dst_tag`  out  `TAG_W`  destination tag of the presented entry.
- `issue_payload`  out  `PAYLOAD_W`  payload of the presented entry.
- `occupancy`  out  `CNT_W`  number of valid entries.

## Operation
- Entry state: `valid`, `src1_rdy`, `src1_tag`, `src2_rdy`, `src2_tag`, `dst_tag`, `payload`.
- Entries are kept age-ordered: index 0 is the oldest, and valid entries are contiguous in `[0, occupancy-1]`.
- Ready condition: `valid & src1_rdy & src2_rdy`.
- Select: the lowest ready index drives `issue_*`. This is combinational from registered state only; `issue_valid` means some entry is ready.
- Issue fire: `issue_valid & issue_ready`.
  - The selected entry is removed.
  - Entries above it shift down by one index in the same edge.
- Dispatch fire: `dispatch_valid & dispatch_ready`.
  - `dispatch_ready = (occupancy < DEPTH)`. It does not credit a same-cycle issue, so there is no issue-to-dispatch combinational path.
  - The new entry is written at index `occupancy - issue_fire`.
- Wakeup, per cycle:
  - A stored source with `rdy == 0` sets `rdy` if any `wb_valid[i]` has `wb_tag[i] == src_tag`.
  - Wakeup applies to shifting entries at their new index.
  - Wakeup also applies to the entry being dispatched (same-cycle bypass): its stored `rdy` is `dispatch_srcN_rdy | match`.
- Flush (highest priority):
  - All `valid` bits clear and `occupancy` becomes 0 on the next edge.
  - Same-cycle dispatch and issue fires are ignored for state update. Execute still sees the combinational `issue_valid` that cycle; discarding it is the flush owner's job.
- Occupancy next value: `occupancy + dispatch_fire - issue_fire`. It never exceeds `DEPTH` and never underflows.

## Timing
- Reset (`rst_aL == 0` at an edge):
  - All `valid` bits become 0 and `occupancy` becomes 0.
  - Consequently `issue_valid` is 0 and `dispatch_ready` is 1 from the cycle after reset.
  - `issue_dst_tag` and `issue_payload` are don't-care while `issue_valid` is 0.
  - A mid-operation reset drops all contents, identical to flush.
- Latency, dispatch to issue:
  - An entry dispatched ready at edge t can present `issue_valid` in cycle t+1.
  - An entry woken by a broadcast in cycle t presents no earlier than cycle t+1.
- Full queue: `dispatch_ready` is 0 while `occupancy == DEPTH`. An issue fire in that cycle raises `dispatch_ready` the next cycle.
- Empty queue: `issue_valid` is 0, and a same-cycle dispatch does not bypass to issue.
- Simultaneous dispatch, issue and wakeup are all applied in a single edge.
- Backpressure: with `issue_ready` low, state holds apart from dispatch and wakeup. The presented entry can change to an older entry if that entry becomes ready.

## Structure
- Shared package (`misc/global_defs.svh`) holds:
  - the `iiq_entry_t` packed typedef, generalised by `TAG_W`/`PAYLOAD_W`;
  - default width constants.
- Sub-module `iiq_wakeup_cmp`: compares one source tag against all `NUM_WB` broadcasts and outputs the match OR.
  - Instantiate 2 per entry, plus 2 for the dispatch bypass.
- Select is a priority encoder over the `DEPTH` ready bits. Collapse is a per-index mux choosing: hold, take index+1, or take the dispatch entry.

## Test plan
- Reset then idle: after reset, `issue_valid == 0`, `dispatch_ready == 1`, `occupancy == 0` for 5 cycles.
- Fill, drain and ordering (`DEPTH = 8`, `issue_ready = 0`):
  - Dispatch 8 ready ops with payloads 1..8; expect `dispatch_ready == 0` and `occupancy == 8`.
  - Raise `issue_ready`; expect payloads issued in order 1..8.
- Wakeup out of order:
  - Dispatch A (`src1` tag 5, not ready) then B (ready); B issues first.
  - Broadcast `wb_tag = 5` on port 1; A issues the next cycle.
- Dispatch bypass: dispatch an op with `src2` tag 9 not ready while `wb_tag[0] = 9` is broadcast the same cycle; it issues the next cycle.
- Collapse under simultaneous events:
  - Start with 4 entries, index 1 ready.
  - In one cycle: issue index 1, dispatch X, wake index 3.
  - Expect `occupancy == 4`, old entries 2 and 3 moved to indices 1 and 2, X at index 3, and the woken entry issuing next.
- Flush with a full queue plus concurrent dispatch: next cycle `occupancy == 0` and `issue_valid == 0`; the dispatched op is absent.

Source files
------------

// File: rtl/int_issue_queue_mp_pkg.sv
// -----------------------------------------------------------------------------
// int_issue_queue_mp_pkg
//   Shared definitions for the integer issue queue.
//   - Default width/size constants used as parameter defaults by the top.
//   - col_sel_e: per-index collapse mux selector.
//   The entry record itself (iiq_entry_t) is declared inside the top module,
//   because its field widths follow the module's TAG_W / PAYLOAD_W parameters.
// -----------------------------------------------------------------------------
package int_issue_queue_mp_pkg;

    localparam int IIQ_DEPTH_DEF     = 8;
    localparam int IIQ_TAG_W_DEF     = 6;
    localparam int IIQ_PAYLOAD_W_DEF = 64;
    localparam int IIQ_NUM_WB_DEF    = 2;

    // What each queue slot loads on the next edge.
    typedef enum logic [1:0] {
        COL_HOLD  = 2'd0,   // keep own (woken) contents
        COL_SHIFT = 2'd1,   // take slot index+1 (collapse after issue)
        COL_DISP  = 2'd2    // take the incoming dispatch entry
    } col_sel_e;

endpackage

// File: rtl/int_issue_queue_mp_wakeup_cmp.sv
// -----------------------------------------------------------------------------
// iiq_wakeup_cmp
//   Compares one source tag against every writeback broadcast port and ORs the
//   hits.
//   Ports:
//     src_tag  in  TAG_W         tag being waited on
//     wb_valid in  NUM_WB        broadcast valid per port
//     wb_tag   in  NUM_WB*TAG_W  packed broadcast tags, port i at [i*TAG_W +: TAG_W]
//     match    out 1             some valid port carries src_tag
// -----------------------------------------------------------------------------
module iiq_wakeup_cmp #(
    parameter int TAG_W  = 6,
    parameter int NUM_WB = 2
) (
    input  logic [TAG_W-1:0]        src_tag,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    output logic                    match
);

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == src_tag)) match = 1'b1;
        end
    end

endmodule

// File: rtl/int_issue_queue_mp.sv
// -----------------------------------------------------------------------------
// int_issue_queue_mp
//   Age-ordered collapsing integer issue queue. Slot 0 is the oldest; valid
//   slots are contiguous in [0, occupancy-1]. Each cycle the lowest ready slot
//   is presented to execute; on issue the slots above it shift down one.
//   Source readiness is woken by NUM_WB tag broadcasts, including a bypass for
//   the entry being dispatched in the same cycle.
//   Ports:
//     clk, rst_aL               clock, synchronous active-low reset
//     flush                     drop all entries (beats dispatch/issue)
//     dispatch_*                dispatch valid/ready handshake + entry fields
//     wb_valid, wb_tag          wakeup broadcasts
//     issue_valid/issue_ready   issue handshake
//     issue_dst_tag/payload     presented entry (don't-care when !issue_valid)
//     occupancy                 number of valid entries
// -----------------------------------------------------------------------------
module int_issue_queue_mp
    import int_issue_queue_mp_pkg::*;
#(
    parameter int DEPTH     = IIQ_DEPTH_DEF,
    parameter int TAG_W     = IIQ_TAG_W_DEF,
    parameter int PAYLOAD_W = IIQ_PAYLOAD_W_DEF,
    parameter int NUM_WB    = IIQ_NUM_WB_DEF,
    parameter int CNT_W     = $clog2(DEPTH+1)
) (
    input  logic                    clk,
    input  logic                    rst_aL,
    input  logic                    flush,
    input  logic                    dispatch_valid,
    output logic                    dispatch_ready,
    input  logic [TAG_W-1:0]        dispatch_src1_tag,
    input  logic [TAG_W-1:0]        dispatch_src2_tag,
    input  logic [TAG_W-1:0]        dispatch_dst_tag,
    input  logic                    dispatch_src1_rdy,
    input  logic                    dispatch_src2_rdy,
    input  logic [PAYLOAD_W-1:0]    dispatch_payload,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    output logic [TAG_W-1:0]        issue_dst_tag,
    output logic [PAYLOAD_W-1:0]    issue_payload,
    output logic [CNT_W-1:0]        occupancy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic                 valid;
        logic                 src1_rdy;
        logic [TAG_W-1:0]     src1_tag;
        logic                 src2_rdy;
        logic [TAG_W-1:0]     src2_tag;
        logic [TAG_W-1:0]     dst_tag;
        logic [PAYLOAD_W-1:0] payload;
    } iiq_entry_t;

    iiq_entry_t       q     [DEPTH];  // registered slots
    iiq_entry_t       q_wk  [DEPTH];  // slots with this cycle's wakeups applied
    iiq_entry_t       q_up  [DEPTH];  // q_wk shifted down by one (collapse source)
    iiq_entry_t       q_nxt [DEPTH];
    col_sel_e         col_sel [DEPTH];
    iiq_entry_t       disp_e;

    logic [CNT_W-1:0] occ_q;
    logic [DEPTH-1:0] wk1, wk2, rdy;
    logic             disp_wk1, disp_wk2;
    logic [IDX_W-1:0] sel_idx;
    logic [CNT_W-1:0] wr_idx;
    logic             issue_fire, dispatch_fire;

    // ---------------- wakeup comparators ----------------
    for (genvar g = 0; g < DEPTH; g++) begin : g_wk
        iiq_wakeup_cmp #(.TAG_W(TAG_W), .NUM_WB(NUM_WB)) u_wk1 (
            .src_tag (q[g].src1_tag),
            .wb_valid(wb_valid),
            .wb_tag  (wb_tag),
            .match   (wk1[g])
        );
        iiq_wakeup_cmp #(.TAG_W(TAG_W), .NUM_WB(NUM_WB)) u_wk2 (
            .src_tag (q[g].src2_tag),
            .wb_valid(wb_valid),
            .wb_tag  (wb_tag),
            .match   (wk2[g])
        );
    end

    // Same-cycle bypass for the entry being dispatched.
    iiq_wakeup_cmp #(.TAG_W(TAG_W), .NUM_WB(NUM_WB)) u_disp_wk1 (
        .src_tag (dispatch_src1_tag),
        .wb_valid(wb_valid),
        .wb_tag  (wb_tag),
        .match   (disp_wk1)
    );
    iiq_wakeup_cmp #(.TAG_W(TAG_W), .NUM_WB(NUM_WB)) u_disp_wk2 (
        .src_tag (dispatch_src2_tag),
        .wb_valid(wb_valid),
        .wb_tag  (wb_tag),
        .match   (disp_wk2)
    );

    // ---------------- select (registered state only) ----------------
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) rdy[i] = q[i].valid & q[i].src1_rdy & q[i].src2_rdy;
        // Walk from the top so the lowest ready index wins.
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (rdy[i]) sel_idx = IDX_W'(i);
        end
    end

    assign issue_valid    = |rdy;
    assign issue_dst_tag  = q[sel_idx].dst_tag;
    assign issue_payload  = q[sel_idx].payload;
    // No credit for a same-cycle issue: keeps issue_ready off the dispatch path.
    assign dispatch_ready = (occ_q < CNT_W'(DEPTH));
    assign occupancy      = occ_q;

    assign issue_fire    = issue_valid & issue_ready;
    assign dispatch_fire = dispatch_valid & dispatch_ready;
    assign wr_idx        = occ_q - CNT_W'(issue_fire);

    always_comb begin
        disp_e          = '0;
        disp_e.valid    = 1'b1;
        disp_e.src1_rdy = dispatch_src1_rdy | disp_wk1;
        disp_e.src1_tag = dispatch_src1_tag;
        disp_e.src2_rdy = dispatch_src2_rdy | disp_wk2;
        disp_e.src2_tag = dispatch_src2_tag;
        disp_e.dst_tag  = dispatch_dst_tag;
        disp_e.payload  = dispatch_payload;
    end

    // ---------------- wakeup + collapse ----------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_wk[i]          = q[i];
            q_wk[i].src1_rdy = q[i].src1_rdy | wk1[i];
            q_wk[i].src2_rdy = q[i].src2_rdy | wk2[i];
        end
        // Wakeup is taken at the old index, so a shifting entry carries it along.
        for (int i = 0; i < DEPTH-1; i++) q_up[i] = q_wk[i+1];
        q_up[DEPTH-1] = '0;

        for (int i = 0; i < DEPTH; i++) begin
            col_sel[i] = COL_HOLD;
            if (issue_fire && (IDX_W'(i) >= sel_idx)) col_sel[i] = COL_SHIFT;
            // Dispatch lands at occupancy - issue_fire, i.e. just past the
            // collapsed tail; it overrides the (invalid) shifted-in slot there.
            if (dispatch_fire && (wr_idx == CNT_W'(i))) col_sel[i] = COL_DISP;

            case (col_sel[i])
                COL_SHIFT: q_nxt[i] = q_up[i];
                COL_DISP:  q_nxt[i] = disp_e;
                default:   q_nxt[i] = q_wk[i];
            endcase
        end
    end

    // ---------------- state ----------------
    // Reset and flush are identical: drop everything, ignore same-cycle fires.
    always_ff @(posedge clk) begin
        if (!rst_aL || flush) begin
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
            occ_q <= occ_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
        end
    end

endmodule

// File: tb/tb_int_issue_queue_mp.sv
module tb_int_issue_queue_mp;

    localparam int DEPTH = 8, TAG_W = 6, PAYLOAD_W = 64, NUM_WB = 2;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic                    clk = 1'b0;
    logic                    rst_aL, flush;
    logic                    dispatch_valid, dispatch_ready;
    logic [TAG_W-1:0]        dispatch_src1_tag, dispatch_src2_tag, dispatch_dst_tag;
    logic                    dispatch_src1_rdy, dispatch_src2_rdy;
    logic [PAYLOAD_W-1:0]    dispatch_payload;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic                    issue_valid, issue_ready;
    logic [TAG_W-1:0]        issue_dst_tag;
    logic [PAYLOAD_W-1:0]    issue_payload;
    logic [CNT_W-1:0]        occupancy;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];   // expected issue order (payloads)

    int_issue_queue_mp #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W), .NUM_WB(NUM_WB)) dut (
        .clk(clk), .rst_aL(rst_aL), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src2_tag(dispatch_src2_tag),
        .dispatch_dst_tag(dispatch_dst_tag),
        .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src2_rdy(dispatch_src2_rdy),
        .dispatch_payload(dispatch_payload),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_dst_tag(issue_dst_tag), .issue_payload(issue_payload),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dst tag is derived from the payload so the monitor can check it too.
    task automatic disp(input logic [63:0] pl, input logic [5:0] t1, input logic r1,
                        input logic [5:0] t2, input logic r2);
        dispatch_valid    = 1'b1;
        dispatch_payload  = pl;
        dispatch_dst_tag  = pl[5:0];
        dispatch_src1_tag = t1;
        dispatch_src1_rdy = r1;
        dispatch_src2_tag = t2;
        dispatch_src2_rdy = r2;
        tick();
        dispatch_valid    = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: every issue fire must match the next expected payload.
    always @(negedge clk) begin
        if (rst_aL && !flush && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                chk("issue_unexpected", issue_payload, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("issue_payload", issue_payload, e);
                chk("issue_dst", 64'(issue_dst_tag), 64'(e[5:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_aL = 1'b0; flush = 1'b0; dispatch_valid = 1'b0;
        dispatch_src1_tag = '0; dispatch_src2_tag = '0; dispatch_dst_tag = '0;
        dispatch_src1_rdy = 1'b0; dispatch_src2_rdy = 1'b0; dispatch_payload = '0;
        wb_valid = '0; wb_tag = '0; issue_ready = 1'b0;
        tick(); tick();
        rst_aL = 1'b1;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            chk("rst_issue_valid", 64'(issue_valid), 64'd0);
            chk("rst_dispatch_ready", 64'(dispatch_ready), 64'd1);
            chk("rst_occupancy", 64'(occupancy), 64'd0);
            tick();
        end

        // Fill, full, drain in order
        for (int i = 1; i <= 8; i++) begin
            disp(64'(i), 6'd0, 1'b1, 6'd0, 1'b1);
            sb.push_back(64'(i));
        end
        chk("full_dispatch_ready", 64'(dispatch_ready), 64'd0);
        chk("full_occupancy", 64'(occupancy), 64'd8);
        chk("full_present_oldest", issue_payload, 64'd1);
        issue_ready = 1'b1;
        tick();
        chk("full_issue_reopens", 64'(dispatch_ready), 64'd1);
        chk("full_occ_after_issue", 64'(occupancy), 64'd7);
        drain("fill_drain");
        issue_ready = 1'b0;
        tick();
        chk("drained_occupancy", 64'(occupancy), 64'd0);
        chk("drained_issue_valid", 64'(issue_valid), 64'd0);

        // Wakeup out of order
        disp(64'hA0, 6'd5, 1'b0, 6'd0, 1'b1);
        disp(64'hB0, 6'd0, 1'b1, 6'd0, 1'b1);
        sb.push_back(64'hB0);
        sb.push_back(64'hA0);
        chk("wk_present_b", issue_payload, 64'hB0);
        issue_ready = 1'b1;
        tick();
        chk("wk_a_blocked", 64'(issue_valid), 64'd0);
        wb_valid = 2'b10;
        wb_tag   = {6'd5, 6'd0};
        tick();
        wb_valid = '0;
        chk("wk_a_ready", 64'(issue_valid), 64'd1);
        chk("wk_a_present", issue_payload, 64'hA0);
        drain("wk_drain");
        issue_ready = 1'b0;

        // Dispatch bypass, and a non-matching broadcast that must not wake
        wb_valid = 2'b01;
        wb_tag   = {6'd0, 6'd9};
        disp(64'hC3, 6'd0, 1'b1, 6'd9, 1'b0);
        wb_valid = '0;
        sb.push_back(64'hC3);
        chk("byp_issue_valid", 64'(issue_valid), 64'd1);
        issue_ready = 1'b1;
        drain("byp_drain");
        issue_ready = 1'b0;
        wb_valid = 2'b01;
        wb_tag   = {6'd0, 6'd9};
        disp(64'hC4, 6'd0, 1'b1, 6'd10, 1'b0);
        wb_valid = '0;
        chk("byp_nomatch_blocked", 64'(issue_valid), 64'd0);
        wb_valid = 2'b01;
        wb_tag   = {6'd0, 6'd10};
        tick();
        wb_valid = '0;
        sb.push_back(64'hC4);
        issue_ready = 1'b1;
        drain("byp_late_drain");
        issue_ready = 1'b0;

        // Collapse: issue idx1, dispatch X, wake idx3 in one edge
        disp(64'h50, 6'd20, 1'b0, 6'd0, 1'b1);
        disp(64'h51, 6'd0,  1'b1, 6'd0, 1'b1);
        disp(64'h52, 6'd21, 1'b0, 6'd0, 1'b1);
        disp(64'h53, 6'd22, 1'b0, 6'd0, 1'b1);
        chk("col_present_idx1", issue_payload, 64'h51);
        sb.push_back(64'h51);
        sb.push_back(64'h53);
        sb.push_back(64'h5F);
        issue_ready = 1'b1;
        wb_valid    = 2'b01;
        wb_tag      = {6'd0, 6'd22};
        disp(64'h5F, 6'd0, 1'b1, 6'd0, 1'b1);
        issue_ready = 1'b0;
        wb_valid    = '0;
        chk("col_occupancy", 64'(occupancy), 64'd4);
        chk("col_woken_present", issue_payload, 64'h53);
        issue_ready = 1'b1;
        tick(); tick();
        chk("col_rest_blocked", 64'(issue_valid), 64'd0);
        chk("col_occ_two", 64'(occupancy), 64'd2);
        sb.push_back(64'h50);
        sb.push_back(64'h52);
        wb_valid = 2'b11;
        wb_tag   = {6'd21, 6'd20};
        tick();
        wb_valid = '0;
        drain("col_drain");
        issue_ready = 1'b0;

        // Flush with a full queue plus concurrent dispatch
        for (int i = 0; i < 8; i++) disp(64'h100 + 64'(i), 6'd0, 1'b1, 6'd0, 1'b1);
        chk("fl_full", 64'(dispatch_ready), 64'd0);
        flush = 1'b1;
        dispatch_valid = 1'b1;
        dispatch_payload = 64'hDEAD;
        tick();
        flush = 1'b0;
        dispatch_valid = 1'b0;
        chk("fl_occupancy", 64'(occupancy), 64'd0);
        chk("fl_issue_valid", 64'(issue_valid), 64'd0);
        chk("fl_dispatch_ready", 64'(dispatch_ready), 64'd1);
        // Partial queue: here the concurrent dispatch could fire, but must not land
        for (int i = 0; i < 3; i++) disp(64'h200 + 64'(i), 6'd0, 1'b1, 6'd0, 1'b1);
        flush = 1'b1;
        disp(64'hEE, 6'd0, 1'b1, 6'd0, 1'b1);
        flush = 1'b0;
        chk("fl2_occupancy", 64'(occupancy), 64'd0);
        chk("fl2_issue_valid", 64'(issue_valid), 64'd0);
        disp(64'h77, 6'd0, 1'b1, 6'd0, 1'b1);
        sb.push_back(64'h77);
        issue_ready = 1'b1;
        drain("fl_post_drain");
        issue_ready = 1'b0;

        // Mid-operation reset drops contents
        for (int i = 0; i < 3; i++) disp(64'h300 + 64'(i), 6'd0, 1'b1, 6'd0, 1'b1);
        rst_aL = 1'b0;
        tick();
        rst_aL = 1'b1;
        chk("mrst_occupancy", 64'(occupancy), 64'd0);
        chk("mrst_issue_valid", 64'(issue_valid), 64'd0);
        disp(64'h78, 6'd0, 1'b1, 6'd0, 1'b1);
        sb.push_back(64'h78);
        issue_ready = 1'b1;
        drain("mrst_drain");
        issue_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
